// File: rtl/fifo_rd_packer.sv
// Pops DATA_WIDTH-bit FIFO entries and packs PACK_RATIO of them, little-endian, into one
// valid/ready output word; flush (or PACKER_TIMEOUT_EN idle timeout) drains a partial word.
module fifo_rd_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK_RATIO     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
    input  logic                             flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int OUT_W = DATA_WIDTH * PACK_RATIO;
    localparam int CNT_W = $clog2(PACK_RATIO + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);
    localparam logic [SUM_W-1:0] FULL_SUM = SUM_W'(PACK_RATIO);

    typedef enum logic {
        S_FILL,
        S_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic [OUT_W-1:0]        acc_data_q, acc_data_d;
    logic                    inflight_q, inflight_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic [PACK_RATIO-1:0]   out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;

    logic                    capture;
    logic [CNT_W-1:0]        cap_cnt;
    logic [OUT_W-1:0]        cap_data;
    logic [SUM_W-1:0]        pend_sum;
    logic                    out_free;
    logic                    flush_req;
    logic                    timeout_hit;
    logic                    load;
    logic                    load_last;
    logic [PACK_RATIO-1:0]   load_keep;

`ifdef PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        timeout_hit = (state_q == S_FILL) && (acc_cnt_q != '0) && !capture &&
                      (idle_q == IDLE_LIMIT);
        if (capture || (acc_cnt_q == '0) || (state_q == S_FLUSH) || timeout_hit) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Pop gate counts the in-flight read so the accumulator can never overfill.
    always_comb begin
        pend_sum   = {1'b0, acc_cnt_q} + SUM_W'(inflight_q);
        fifo_rd_en = !fifo_empty && (state_q == S_FILL) && (pend_sum < FULL_SUM);
        inflight_d = fifo_rd_en;
    end

    always_comb begin
        capture  = inflight_q;
        cap_data = acc_data_q;
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (capture && (acc_cnt_q == CNT_W'(i))) begin
                cap_data[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
            end
        end
        cap_cnt   = acc_cnt_q + CNT_W'(capture);
        out_free  = !out_valid_q || out_ready;
        flush_req = (flush || timeout_hit) && (state_q == S_FILL);
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            load_keep[i] = (CNT_W'(i) < cap_cnt);
        end
    end

    // A flush in the cycle the last byte lands defers the close to FLUSH so it carries last=1.
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = cap_cnt;
        acc_data_d  = cap_data;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;
        load        = 1'b0;
        load_last   = 1'b0;

        case (state_q)
            S_FILL: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if ((cap_cnt == FULL_CNT) && out_free) begin
                    load = 1'b1;
                end
            end
            S_FLUSH: begin
                if (!inflight_q) begin
                    if (acc_cnt_q == '0) begin
                        state_d = S_FILL;
                    end else if (out_free) begin
                        load      = 1'b1;
                        load_last = 1'b1;
                        state_d   = S_FILL;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase

        // Accumulator lanes are cleared on every load, so unused lanes are already zero.
        if (load) begin
            out_data_d  = cap_data;
            out_keep_d  = load_keep;
            out_last_d  = load_last;
            out_valid_d = 1'b1;
            acc_cnt_d   = '0;
            acc_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            acc_cnt_q   <= '0;
            acc_data_q  <= '0;
            inflight_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_data_q  <= acc_data_d;
            inflight_q  <= inflight_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (acc_cnt_q != '0) || inflight_q || out_valid_q || (state_q == S_FLUSH);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model, scoreboard of expected words, vector table plus
// hand-written stall, coincident-flush, reset and timeout sequences.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PR = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          flush = 1'b0;
    logic [31:0]   out_data;
    logic [PR-1:0] out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    fifo_rd_packer #(
        .DATA_WIDTH    (DW),
        .PACK_RATIO    (PR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .flush       (flush),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        bit          fl;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
    } vec_t;

    word_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int            total = 0;
    int            bad = 0;
    int            pop_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // FIFO model: pop decided on the registered rd_en, data valid the cycle after.
    always begin
        logic p;
        @(negedge clk);
        p = fifo_rd_en;
        if (p) chk("pop_not_empty", {31'd0, fifo_empty}, 32'd0);
        @(posedge clk);
        #1;
        if (p && fifo_q.size() != 0) begin
            fifo_rd_data = fifo_q.pop_front();
            pop_count++;
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h keep %h last %b want none",
                         out_data, out_keep, out_last);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                chk("word_data", out_data, e.data);
                chk("word_keep", {28'd0, out_keep}, {28'd0, e.keep});
                chk("word_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic wait_pops(input int target, input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (pop_count >= target) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        chk(name, ok, 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            cyc(1);
            if (exp_q.size() == 0 && !busy && fifo_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   base;
        int   ok;
        int   seen;

        vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF, 1'b0};
        vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'h3, 1'b1};
        vecs[2] = '{1, 32'h0000007E, 1'b1, 32'h0000007E, 4'h1, 1'b1};
        vecs[3] = '{3, 32'h00C0B0A0, 1'b1, 32'h00C0B0A0, 4'h7, 1'b1};
        vecs[4] = '{4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'hF, 1'b0};

        cyc(3);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_keep", {28'd0, out_keep}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        cyc(2);

        for (int v = 0; v < 5; v++) begin
            base = pop_count;
            for (int j = 0; j < vecs[v].n; j++) fifo_q.push_back(vecs[v].bytes[8*j +: 8]);
            expect_word(vecs[v].ed, vecs[v].ek, vecs[v].el);
            if (vecs[v].fl) begin
                wait_pops(base + vecs[v].n, "vec_pops");
                cyc(2);
                pulse_flush();
            end
            wait_drain(60, "vec_drain");
        end

        // Flush with an empty accumulator: no word, busy falls quickly.
        pulse_flush();
        ok = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        chk("flush_empty_busy", ok, 1);

        // Backpressure: output held, accumulator fills, pops stall at 8.
        out_ready = 1'b0;
        base = pop_count;
        for (int j = 1; j <= 10; j++) fifo_q.push_back(8'(j));
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (i >= 10) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", out_data, 32'h04030201);
            end
        end
        chk("stall_pops", pop_count - base, 8);
        out_ready = 1'b1;
        cyc(1);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_data", out_data, 32'h08070605);
        wait_pops(base + 10, "tail_pops");
        cyc(2);
        expect_word(32'h00000A09, 4'h3, 1'b1);
        pulse_flush();
        wait_drain(60, "tail_drain");

        // Flush lands in the same cycle as the 4th byte.
        base = pop_count;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        fifo_q.push_back(8'hCC);
        fifo_q.push_back(8'hDD);
        expect_word(32'hDDCCBBAA, 4'hF, 1'b1);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (pop_count == base + 4) begin
                ok = 1;
                break;
            end
        end
        chk("coinc_pops", ok, 1);
        pulse_flush();
        wait_drain(60, "coinc_drain");

        // Async reset with a held word and a partial accumulator.
        out_ready = 1'b0;
        for (int j = 0; j < 7; j++) fifo_q.push_back(8'h10 + 8'(j));
        cyc(15);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_data", out_data, 32'd0);
        chk("async_keep", {28'd0, out_keep}, 32'd0);
        chk("async_last", {31'd0, out_last}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        exp_q.delete();
        fifo_q.delete();
        cyc(2);
        rst = 1'b0;
        out_ready = 1'b1;
        cyc(1);
        for (int j = 0; j < 4; j++) fifo_q.push_back(8'h21 + 8'(j));
        expect_word(32'h24232221, 4'hF, 1'b0);
        wait_drain(60, "post_rst_drain");

        // Idle partial word: auto-flush only in the timeout build.
        base = pop_count;
        fifo_q.push_back(8'h5A);
        expect_word(32'h0000005A, 4'h1, 1'b1);
        wait_pops(base + 1, "idle_pops");
`ifdef PACKER_TIMEOUT_EN
        cyc(4);
        chk("timeout_not_early", {31'd0, out_valid}, 32'd0);
        wait_drain(30, "timeout_drain");
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (out_valid) seen = 1;
        end
        chk("no_timeout", seen, 0);
        pulse_flush();
        wait_drain(30, "idle_flush_drain");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
